// File: rtl/dff_monitor_pkg.sv
// Shared definitions for the flip-flop response monitor: FSM state encoding
// and the default counter width.
package dff_monitor_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WARMUP = 2'b01,
      ST_CHECK  = 2'b10,
      ST_FAIL   = 2'b11
   } state_e;

endpackage

// File: rtl/dff_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; it holds at all-ones instead
// of wrapping.
module dff_monitor_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign q = r_cnt;

endmodule

// File: rtl/dff_monitor.sv
// Response monitor for a flip-flop under test: it compares q against a
// LATENCY-deep d pipeline, checks qn against ~q, and counts errors and toggles.
module dff_monitor
   import dff_monitor_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int CNT_W   = CNT_W_DEF,
   parameter bit HALT    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d,
   input  logic             q,
   input  logic             qn,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] checked,
   output logic [CNT_W-1:0] q_err,
   output logic [CNT_W-1:0] qn_err,
   output logic [CNT_W-1:0] toggles,
   output logic             fail,
   output logic [CNT_W-1:0] first_fail
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [LATENCY-1:0] r_pipe;
   logic [2:0]         r_warm;
   logic               r_prev_q;
   logic               r_prev_vld;
   logic               r_fail;
   logic [CNT_W-1:0]   r_first_fail;

   logic w_exp, w_chk, w_shift, w_q_bad, w_qn_bad, w_err, w_toggle;

   always_comb begin
      w_state_nxt = r_state;
      w_exp       = r_pipe[LATENCY-1];
      w_chk       = (r_state == ST_CHECK) && en;
      w_shift     = ((r_state == ST_WARMUP) || (r_state == ST_CHECK)) && en;
      // Case inequality so an X/Z on q or qn is reported as a mismatch.
      w_q_bad     = (q !== w_exp);
      w_qn_bad    = (qn !== ~q);
      w_err       = w_chk && (w_q_bad || w_qn_bad);
      w_toggle    = w_chk && r_prev_vld && (q !== r_prev_q);
      case (r_state)
         ST_IDLE: begin
            if (en) w_state_nxt = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!en)                              w_state_nxt = ST_IDLE;
            else if (r_warm == 3'(LATENCY - 1))   w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (!en)                w_state_nxt = ST_IDLE;
            else if (HALT && w_err) w_state_nxt = ST_FAIL;
         end
         default: w_state_nxt = ST_FAIL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pipe       <= '0;
         r_warm       <= '0;
         r_prev_q     <= 1'b0;
         r_prev_vld   <= 1'b0;
         r_fail       <= 1'b0;
         r_first_fail <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_shift) begin
            r_pipe[0] <= d;
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
         end
         if (r_state == ST_WARMUP) r_warm <= r_warm + 3'd1;
         else                      r_warm <= '0;
         if (w_chk) r_prev_q <= q;
         // The first CHECK edge after (re)arming has no q history to toggle against.
         r_prev_vld <= w_chk;
         if (w_err) begin
            r_fail <= 1'b1;
            if (!r_fail) r_first_fail <= checked;
         end
      end
   end

   dff_monitor_sat_counter #(.CNT_W(CNT_W)) u_checked (
      .clk(clk), .rst(rst), .inc(w_chk), .clr(1'b0), .q(checked));
   dff_monitor_sat_counter #(.CNT_W(CNT_W)) u_q_err (
      .clk(clk), .rst(rst), .inc(w_chk && w_q_bad), .clr(1'b0), .q(q_err));
   dff_monitor_sat_counter #(.CNT_W(CNT_W)) u_qn_err (
      .clk(clk), .rst(rst), .inc(w_chk && w_qn_bad), .clr(1'b0), .q(qn_err));
   dff_monitor_sat_counter #(.CNT_W(CNT_W)) u_toggles (
      .clk(clk), .rst(rst), .inc(w_toggle), .clr(1'b0), .q(toggles));

   assign state      = r_state;
   assign fail       = r_fail;
   assign first_fail = r_first_fail;

endmodule

// File: tb/tb_dff_monitor.sv
// Directed bench for dff_monitor: several parameterisations watch bench-modelled
// 1- and 2-stage flip-flops with injectable stuck, inverted and qn-tie faults.
module tb_dff_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic d   = 1'b0;
   logic tog_d = 1'b0;
   logic f_stuck0 = 1'b0, f_flip = 1'b0, f_qn_tied = 1'b0;
   logic ff1 = 1'b0, ff2a = 1'b0, ff2 = 1'b0;
   logic q_l1, qn_l1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ff1  <= d;
      ff2a <= d;
      ff2  <= ff2a;
   end

   assign q_l1  = f_stuck0 ? 1'b0 : (f_flip ? ~ff1 : ff1);
   assign qn_l1 = f_qn_tied ? q_l1 : ~q_l1;

   logic [1:0]  st_a, st_h, st_b, st_c, st_s;
   logic [15:0] ck_a, qe_a, ne_a, tg_a, ff_a;
   logic [15:0] ck_h, qe_h, ne_h, tg_h, ff_h;
   logic [15:0] ck_b, qe_b, ne_b, tg_b, ff_b;
   logic [15:0] ck_c, qe_c, ne_c, tg_c, ff_c;
   logic [3:0]  ck_s, qe_s, ne_s, tg_s, ff_s;
   logic        fl_a, fl_h, fl_b, fl_c, fl_s;

   dff_monitor #(.LATENCY(1), .CNT_W(16), .HALT(1'b0)) u_l1 (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(q_l1), .qn(qn_l1),
      .state(st_a), .checked(ck_a), .q_err(qe_a), .qn_err(ne_a),
      .toggles(tg_a), .fail(fl_a), .first_fail(ff_a));
   dff_monitor #(.LATENCY(1), .CNT_W(16), .HALT(1'b1)) u_h (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(q_l1), .qn(qn_l1),
      .state(st_h), .checked(ck_h), .q_err(qe_h), .qn_err(ne_h),
      .toggles(tg_h), .fail(fl_h), .first_fail(ff_h));
   dff_monitor #(.LATENCY(2), .CNT_W(16), .HALT(1'b0)) u_l2 (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(ff2), .qn(~ff2),
      .state(st_b), .checked(ck_b), .q_err(qe_b), .qn_err(ne_b),
      .toggles(tg_b), .fail(fl_b), .first_fail(ff_b));
   dff_monitor #(.LATENCY(1), .CNT_W(16), .HALT(1'b0)) u_l1b (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(ff2), .qn(~ff2),
      .state(st_c), .checked(ck_c), .q_err(qe_c), .qn_err(ne_c),
      .toggles(tg_c), .fail(fl_c), .first_fail(ff_c));
   dff_monitor #(.LATENCY(1), .CNT_W(4), .HALT(1'b0)) u_s4 (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(q_l1), .qn(qn_l1),
      .state(st_s), .checked(ck_s), .q_err(qe_s), .qn_err(ne_s),
      .toggles(tg_s), .fail(fl_s), .first_fail(ff_s));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Each step is one rising edge; inputs change and outputs are sampled on negedges.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tog_d) d = ~d;
      end
   endtask

   task automatic restart();
      rst = 1'b1; en = 1'b0; tog_d = 1'b0; d = 1'b0;
      f_stuck0 = 1'b0; f_flip = 1'b0; f_qn_tied = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_state", st_a, 0);
      check("rst_checked", ck_a, 0);
      check("rst_fail", fl_a, 0);
      check("rst_first_fail", ff_a, 0);
      rst = 1'b0;

      // Ideal DFF with toggling d: 41 armed edges = 1 idle + 1 warmup + 39 checks
      d = 1'b0; tog_d = 1'b1; en = 1'b1;
      step(41);
      check("ideal_state", st_a, 2);
      check("ideal_checked", ck_a, 39);
      check("ideal_q_err", qe_a, 0);
      check("ideal_qn_err", ne_a, 0);
      check("ideal_toggles", tg_a, 38);
      check("ideal_fail", fl_a, 0);
      check("halt_ok_state", st_h, 2);
      check("lat2_checked", ck_b, 38);
      check("lat2_q_err", qe_b, 0);
      check("lat2_fail", fl_b, 0);
      check("lat1_vs_2stage_q_err", qe_c, 39);
      check("lat1_vs_2stage_first", ff_c, 0);
      check("sat_checked", ck_s, 15);
      check("sat_ideal_q_err", qe_s, 0);

      // q stuck-at-0 from checked=5 with d held at 1
      restart();
      d = 1'b1; en = 1'b1;
      step(7);
      check("stuck_pre_checked", ck_a, 5);
      f_stuck0 = 1'b1;
      step(5);
      check("stuck_checked", ck_a, 10);
      check("stuck_q_err", qe_a, 5);
      check("stuck_qn_err", ne_a, 0);
      check("stuck_fail", fl_a, 1);
      check("stuck_first_fail", ff_a, 5);
      check("stuck_toggles", tg_a, 1);
      check("stuck_state", st_a, 2);
      check("stuck_halt_state", st_h, 3);
      check("stuck_halt_checked", ck_h, 6);
      check("stuck_halt_q_err", qe_h, 1);

      // qn tied to q instead of inverted
      restart();
      f_qn_tied = 1'b1; d = 1'b0; tog_d = 1'b1; en = 1'b1;
      step(10);
      check("qntie_checked", ck_a, 8);
      check("qntie_qn_err", ne_a, 8);
      check("qntie_q_err", qe_a, 0);
      check("qntie_first_fail", ff_a, 0);
      check("qntie_fail", fl_a, 1);

      // Single corrupted q at checked=3, then en toggling
      restart();
      d = 1'b0; tog_d = 1'b1; en = 1'b1;
      step(5);
      f_flip = 1'b1;
      step(1);
      f_flip = 1'b0;
      step(3);
      en = 1'b0;
      step(2);
      check("once_idle_state", st_a, 0);
      check("once_idle_checked", ck_a, 7);
      check("once_q_err", qe_a, 1);
      check("once_first_fail", ff_a, 3);
      check("once_fail_kept", fl_a, 1);
      en = 1'b1;
      step(2);
      check("halt_state", st_h, 3);
      check("halt_checked", ck_h, 4);
      check("halt_q_err", qe_h, 1);
      check("halt_first_fail", ff_h, 3);
      check("halt_fail", fl_h, 1);

      // 20 mismatching edges: 4-bit counters saturate, then async reset mid-CHECK
      restart();
      f_flip = 1'b1; d = 1'b0; tog_d = 1'b1; en = 1'b1;
      step(22);
      check("sat_q_err", qe_s, 15);
      check("sat_checked_cap", ck_s, 15);
      check("wide_q_err", qe_a, 20);
      rst = 1'b1;
      #1;
      check("arst_state", st_a, 0);
      check("arst_checked", ck_a, 0);
      check("arst_q_err", qe_a, 0);
      check("arst_toggles", tg_a, 0);
      check("arst_fail", fl_a, 0);
      check("arst_sat_q_err", qe_s, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
